// File: rtl/branch_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_flush_ctrl_if
// Brief    : EX-stage resolve / PC redirect / flush bundle for branch_flush_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface branch_flush_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              stall_in;
    logic              ex_valid;
    logic              ex_is_branch;
    logic              ex_is_jal;
    logic              ex_is_jalr;
    logic              ex_taken;
    logic              ex_pred_taken;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_target;
    logic [31:0]       if_pc;
    logic              if_pred_taken;
    logic              pc_redirect;
    logic [31:0]       redirect_pc;
    logic              flush_ifid;
    logic              flush_idex;
    logic              busy;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    modport master (
        output stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_taken, ex_pred_taken, ex_pc, ex_target, if_pc,
        input  if_pred_taken, pc_redirect, redirect_pc, flush_ifid,
               flush_idex, busy, branch_cnt, mispred_cnt
    );

    modport slave (
        input  stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_taken, ex_pred_taken, ex_pc, ex_target, if_pc,
        output if_pred_taken, pc_redirect, redirect_pc, flush_ifid,
               flush_idex, busy, branch_cnt, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_flush_ctrl
// Brief    : Branch resolution sequencer: PC redirect, pipeline flushes, perf
//            counters. Optional BHT predictor enabled by macro BRANCH_PRED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_flush_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 16,
    parameter int PERF_W       = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    branch_flush_ctrl_if.slave  bus
);
    localparam int       c_CNT_W    = 3;
    localparam bit [1:0] c_ST_RUN   = 2'd0;
    localparam bit [1:0] c_ST_HOLD  = 2'd1;
    localparam bit [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [c_CNT_W-1:0] r_fcnt;
    logic               r_first;
    logic [31:0]        r_target;
    logic               r_act_taken;
    logic [PERF_W-1:0]  r_branch_cnt;
    logic [PERF_W-1:0]  r_mispred_cnt;

    logic        w_jump;
    logic        w_resolve;
    logic        w_act_taken;
    logic        w_mispred;
    logic [31:0] w_tgt;

    // Only RUN qualifies a resolve: in HOLD/FLUSH the EX instruction is frozen or wrong-path.
    assign w_jump      = bus.ex_is_jal | bus.ex_is_jalr;
    assign w_resolve   = bus.ex_valid & (bus.ex_is_branch | w_jump) & (r_state == c_ST_RUN);
    assign w_act_taken = w_jump | bus.ex_taken;
    assign w_mispred   = w_jump | (bus.ex_is_branch & (bus.ex_taken ^ bus.ex_pred_taken));
    assign w_tgt       = w_act_taken ? {bus.ex_target[31:1], 1'b0} : (bus.ex_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_resolve && w_mispred) begin
                    w_state_nx = bus.stall_in ? c_ST_HOLD : c_ST_FLUSH;
                end
            end
            c_ST_HOLD: begin
                if (!bus.stall_in) begin
                    w_state_nx = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                if ((r_fcnt == '0) && !bus.stall_in) begin
                    w_state_nx = c_ST_RUN;
                end
            end
            default: w_state_nx = c_ST_RUN;
        endcase
    end

    always_comb begin
        bus.pc_redirect = (r_state == c_ST_FLUSH) & r_first;
        bus.flush_ifid  = (r_state == c_ST_FLUSH);
        bus.flush_idex  = (r_state == c_ST_FLUSH);
        bus.busy        = (r_state != c_ST_RUN);
        bus.redirect_pc = r_target;
        bus.branch_cnt  = r_branch_cnt;
        bus.mispred_cnt = r_mispred_cnt;
    end

    // Flush length counter freezes under stall so flushes span FLUSH_CYCLES live cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_first <= 1'b0;
        end else if ((r_state != c_ST_FLUSH) && (w_state_nx == c_ST_FLUSH)) begin
            r_fcnt  <= c_CNT_W'(FLUSH_CYCLES - 1);
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if ((r_state == c_ST_FLUSH) && !bus.stall_in && (r_fcnt != '0)) begin
                r_fcnt <= r_fcnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target      <= '0;
            r_act_taken   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            r_target     <= w_tgt;
            r_act_taken  <= w_act_taken;
            r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispred) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

`ifdef BRANCH_PRED_EN
    localparam int c_IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic [1:0]         r_bht [BHT_ENTRIES];
    logic [c_IDX_W-1:0] w_if_idx;
    logic [c_IDX_W-1:0] w_ex_idx;
    logic               w_unused;

    assign w_if_idx          = bus.if_pc[c_IDX_W+1:2];
    assign w_ex_idx          = bus.ex_pc[c_IDX_W+1:2];
    assign bus.if_pred_taken = r_bht[w_if_idx][1];
    assign w_unused          = ^{bus.if_pc[31:c_IDX_W+2], bus.if_pc[1:0], r_act_taken};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_resolve && bus.ex_is_branch) begin
            if (bus.ex_taken && (r_bht[w_ex_idx] != 2'b11)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
            end else if (!bus.ex_taken && (r_bht[w_ex_idx] != 2'b00)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
            end
        end
    end
`else
    logic w_unused;

    assign bus.if_pred_taken = 1'b0;
    assign w_unused          = ^{bus.if_pc, r_act_taken, (BHT_ENTRIES != 0)};
`endif

endmodule
`default_nettype wire

// File: doc/branch_flush_ctrl.md
Name: branch_flush_ctrl

Overview:
- Sequences control-flow resolution for the pipelined RV32I core.
- Consumes the EX-stage branch decision (branch unit output `r`) together with the front-end prediction, and generates the PC redirect and the IF/ID and ID/EX flush pulses.
- Holds a redirect that arrives while the pipeline is stalled, and keeps branch and mispredict performance counters.
- Sits between the EX stage, the PC register and the pipeline-register flush controls.

Parameters:
- FLUSH_CYCLES, 2: number of cycles flush_ifid/flush_idex stay asserted per redirect; legal range 1..7.
- BHT_ENTRIES, 16: predictor table depth; power of 2; used only with BRANCH_PRED_EN.
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stall_in  in  1  pipeline freeze (hazard or memory stall).
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jal  in  1  EX instruction is JAL.
- ex_is_jalr  in  1  EX instruction is JALR.
- ex_taken  in  1  branch unit decision (`r`).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch/jump target.
- if_pc  in  32  current fetch PC.
- if_pred_taken  out  1  prediction for if_pc.
- pc_redirect  out  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  out  32  redirect address; valid while pc_redirect=1.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- busy  out  1  state != RUN.
- branch_cnt  out  PERF_W  resolved control-flow instructions.
- mispred_cnt  out  PERF_W  redirects issued.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State RUN.
  - All outputs 0; redirect_pc = 0.
  - Counters 0; FLUSH counter 0.
  - Every BHT entry set to 2'b01.
  - rst overrides all other inputs in every state and aborts HOLD/FLUSH with no redirect emitted.
- Resolve event: ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr), qualified only in RUN; ignored in HOLD and FLUSH because those instructions are wrong-path or frozen.
- actual_taken = ex_is_jal | ex_is_jalr | ex_taken.
- Mispredict condition:
  - ex_is_jal or ex_is_jalr: always a mispredict.
  - ex_is_branch: mispredict when ex_taken != ex_pred_taken.
- Redirect target: actual_taken ? {ex_target[31:1],1'b0} : ex_pc + 4, 32-bit wraparound (0xFFFFFFFC + 4 = 0).
- Target and actual_taken are captured into registers on the resolve edge.
- FSM:
  - RUN, resolve & mispredict & ~stall_in → FLUSH; pc_redirect=1 in the first FLUSH cycle.
  - RUN, resolve & mispredict & stall_in → HOLD; target latched, no pulse yet.
  - RUN, otherwise → RUN.
  - HOLD: stays while stall_in=1; stall_in=0 → FLUSH with the pc_redirect pulse.
  - FLUSH:
    - flush_ifid = flush_idex = 1 for the whole state.
    - pc_redirect high only in the first cycle.
    - Counter loads FLUSH_CYCLES-1 on entry and decrements each cycle with stall_in=0; it freezes while stall_in=1.
    - Exits to RUN when the counter is 0 and stall_in=0.
- Latency:
  - Unstalled: pc_redirect asserts exactly one cycle after the resolve edge.
  - flush outputs are high for exactly FLUSH_CYCLES unstalled cycles.
- A resolve is never lost; a second mispredict cannot occur while busy=1.
- Counters:
  - branch_cnt +1 on each qualified resolve.
  - mispred_cnt +1 on each qualified mispredict (counted at resolve, even if it then goes to HOLD).
  - Both wrap modulo 2^PERF_W.
  - Counter updates occur regardless of stall_in.

Optional Feature:
- Macro BRANCH_PRED_EN.
- Defined:
  - BHT of BHT_ENTRIES 2-bit saturating counters, indexed by if_pc[log2(BHT_ENTRIES)+1:2].
  - if_pred_taken = entry[1], combinational.
  - On a qualified resolve with ex_is_branch=1, the entry indexed by ex_pc is incremented if ex_taken (saturating at 3) or decremented otherwise (saturating at 0).
  - JAL/JALR do not update the BHT.
- Not defined: no table is instantiated; if_pred_taken is tied to 0 (static not-taken); BHT_ENTRIES is unused.

Test Plan:
- rst held 3 cycles, then released → all outputs 0, busy=0; both counters 0; BHT index 0 gives if_pred_taken=0.
- Branch with ex_pc=0x100, ex_taken=1, pred=0, target=0x80, no stall → next cycle pc_redirect=1 with redirect_pc=0x80; flushes high 2 cycles; branch_cnt=1, mispred_cnt=1.
- Branch with ex_pc=0x200, ex_taken=0, pred=0 → no redirect, no flush; branch_cnt +1, mispred_cnt unchanged. Branch with ex_taken=0, pred=1 → redirect_pc=0x204.
- JALR with target=0x1235 and stall_in=1 for 4 cycles → state HOLD with no pulse; pulse on the first cycle after stall drops, redirect_pc=0x1234. Also assert rst during HOLD → RUN, no pulse.
- With FLUSH_CYCLES=3: resolve during FLUSH is ignored; stall_in=1 mid-FLUSH freezes the counter so flushes stay high 3 unstalled cycles; ex_pc=0xFFFFFFFC not-taken mispredict → redirect_pc=0x0.
- With BRANCH_PRED_EN: branch at 0x40 taken twice → if_pred_taken for if_pc=0x40 becomes 1 after the first update (01→10) and stays 1 at saturation 11; three not-taken updates bring it to 0. Counter-wrap check with PERF_W=4: 16 resolves → branch_cnt=0.
